// File: rtl/isu_fetch_ctrl.sv
// Fetch sequencer: ROM read issued the cycle after start/redirect, word presented 2 cycles later; 1 instr/cycle.
// Backpressure: 2-entry output buffer, issue stalls when buffer + in-flight would exceed 2. Optional ISU_FETCH_PERF_EN adds perf counters.
module isu_fetch_ctrl #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               mem_en,
  output logic [A_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0] mem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc,
  output logic               busy
`ifdef ISU_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] pc;
  logic [A_WIDTH-1:0] inflight_pc;
  logic               inflight;
  logic [1:0]         count, count_nxt;
  logic [D_WIDTH-1:0] b1_instr;
  logic [A_WIDTH-1:0] b1_pc;
  logic               pop, cap, issue, wr_b1, busy_nxt;
  logic [2:0]         occ;
  logic               unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign pop   = out_valid & out_ready;
  // A redirect squashes the word returning this cycle.
  assign cap   = inflight & ~redirect_valid;
  assign occ   = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue = (state == S_RUN) & ~redirect_valid & ~stop & (occ < 3'd2);

  assign mem_en   = issue;
  assign mem_addr = pc;

  assign wr_b1     = (count == 2'd2) | ((count == 2'd1) & ~pop);
  assign count_nxt = redirect_valid ? 2'd0 : (count + {1'b0, cap} - {1'b0, pop});

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!redirect_valid && start) state_nxt = S_RUN;
      S_RUN:   if (!redirect_valid && stop)  state_nxt = S_DRAIN;
      S_DRAIN: if (redirect_valid || (count == 2'd0 && !inflight)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != S_IDLE) | (count_nxt != 2'd0) | issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      b1_instr    <= '0;
      b1_pc       <= '0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != 2'd0);
      busy      <= busy_nxt;
      inflight  <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + A_WIDTH'(4);
      end
      if (redirect_valid)
        pc <= {redirect_pc[A_WIDTH-1:2], 2'b00};
      if (!redirect_valid) begin
        if (pop) begin
          out_instr <= b1_instr;
          out_pc    <= b1_pc;
        end
        // Capture lands behind whatever survives this cycle's pop.
        if (cap) begin
          if (wr_b1) begin
            b1_instr <= mem_dout;
            b1_pc    <= inflight_pc;
          end else begin
            out_instr <= mem_dout;
            out_pc    <= inflight_pc;
          end
        end
      end
    end
  end

`ifdef ISU_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (out_valid && !out_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isu_fetch_ctrl.sv
// Bench for isu_fetch_ctrl: vector table plus scoreboard of expected output PCs/words.
module tb_isu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
`ifdef ISU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rst, start, stop, redir;
    logic [31:0] rpc;
    logic        ready, chk, en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  isu_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
`ifdef ISU_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // ROM with a one-cycle registered read
  always @(posedge clk) if (mem_en) mem_dout <= rom_word(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the next expected PC and its ROM word.
  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=0x%08h expected=none", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb.out_pc", out_pc, e);
        check("sb.out_instr", out_instr, rom_word(e));
      end
    end
  end

  task automatic sb_reset(input logic [31:0] base);
    @(posedge clk);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic rd,
                              input logic [31:0] rpc, input logic rdy, input logic chk,
                              input logic en, input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc, input logic bsy);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.redir = rd; v.rpc = rpc; v.ready = rdy;
    v.chk = chk; v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.bsy = bsy;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; start = v.start; stop = v.stop;
    redirect_valid = v.redir; redirect_pc = v.rpc; out_ready = v.ready;
    #1;
    if (v.chk) begin
      check({name, ".mem_en"}, mem_en, v.en);
      if (v.en) check({name, ".mem_addr"}, mem_addr, v.addr);
      check({name, ".out_valid"}, out_valid, v.vld);
      if (v.vld) check({name, ".out_pc"}, out_pc, v.pc);
      check({name, ".busy"}, busy, v.bsy);
    end
  endtask

  initial begin
    sb_reset(32'h0);
    // reset, start, stream, 5-cycle stall, release
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h00,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h04,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h08,1,32'h00,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h0C,1,32'h04,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h10,1,32'h08,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h14,1,32'h0C,1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,1,32'h10,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h18,1,32'h10,1));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,32'h1C,1,32'h14,1));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
      if (i == 2) begin
        check("reset.mem_addr", mem_addr, 32'h0);
        check("reset.out_instr", out_instr, 32'h0);
        check("reset.out_pc", out_pc, 32'h0);
      end
    end

    // redirect to 0x43 with a read in flight (0x1C is squashed)
    step(mk(0,0,0,1,32'h43,1, 1,0,0,1,32'h18,1), "redir");
    sb_reset(32'h40);
    step(mk(0,0,0,0,0,1, 1,1,32'h40,0,0,1), "redir_n1");
    step(mk(0,0,0,0,0,1, 1,1,32'h44,0,0,1), "redir_n2");
    step(mk(0,0,0,0,0,1, 1,1,32'h48,1,32'h40,1), "redir_n3");

    // stop with one buffered and one in flight
    step(mk(0,0,1,0,0,1, 1,0,0,1,32'h44,1), "stop");
    step(mk(0,0,0,0,0,1, 1,0,0,1,32'h48,1), "drain1");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,1), "drain2");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,0), "idle1");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,0), "idle2");

    // restart from 0x4C, then reset while words are buffered
    sb_reset(32'h4C);
    step(mk(0,1,0,0,0,1, 1,0,0,0,0,0), "restart");
    step(mk(0,0,0,0,0,1, 1,1,32'h4C,0,0,1), "rs_n1");
    step(mk(0,0,0,0,0,1, 1,1,32'h50,0,0,1), "rs_n2");
    step(mk(0,0,0,0,0,1, 1,1,32'h54,1,32'h4C,1), "rs_n3");
    step(mk(0,0,0,0,0,0, 1,0,0,1,32'h50,1), "rs_hold");
    step(mk(1,0,0,0,0,0, 1,0,0,1,32'h50,1), "rst_hit");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,0), "rst_after");
    check("rst_after.mem_addr", mem_addr, 32'h0);
    check("rst_after.out_instr", out_instr, 32'h0);
    check("rst_after.out_pc", out_pc, 32'h0);

    // refetch from RESET_PC: 10 accepted words, 3 stall cycles, then stop
    sb_reset(32'h0);
    step(mk(0,1,0,0,0,1, 1,0,0,0,0,0), "p_start");
    step(mk(0,0,0,0,0,1, 1,1,32'h00,0,0,1), "p2");
    step(mk(0,0,0,0,0,1, 1,1,32'h04,0,0,1), "p3");
    for (int c = 0; c < 5; c++)
      step(mk(0,0,0,0,0,1, 1,1,32'(4*c+8),1,32'(4*c),1), $sformatf("p_run%0d", c));
    for (int c = 0; c < 3; c++)
      step(mk(0,0,0,0,0,0, 1,0,0,1,32'h14,1), $sformatf("p_stall%0d", c));
    for (int c = 0; c < 3; c++)
      step(mk(0,0,0,0,0,1, 1,1,32'(32'h1C+4*c),1,32'(32'h14+4*c),1), $sformatf("p_rel%0d", c));
    step(mk(0,0,1,0,0,1, 1,0,0,1,32'h20,1), "p_stop");
    step(mk(0,0,0,0,0,1, 1,0,0,1,32'h24,1), "p_drain1");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,1), "p_drain2");
    step(mk(0,0,0,0,0,1, 1,0,0,0,0,0), "p_idle");
`ifdef ISU_FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    check("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isu_fetch_ctrl.md
# isu_fetch_ctrl

Instruction fetch sequencer sitting between the program counter logic and the instruction ROM (`isu_mem`, 1-cycle registered read). It owns the fetch PC, issues `en`/`addr` to the ROM, captures returned words into a 2-entry output buffer, and presents them to decode over a valid/ready handshake. It handles start, stop/drain and branch redirect, squashing any read in flight, and sustains one instruction per cycle.

## Interface
- `A_WIDTH`, 32, address/PC width
- `D_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h00000000, PC loaded on reset; bits [1:0] must be zero

- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset; also drives the ROM `rst`
- `start`  in  1  begin fetching from current PC; honoured only in IDLE
- `stop`  in  1  stop issuing and drain; honoured only in RUN
- `redirect_valid`  in  1  load new PC and flush buffer
- `redirect_pc`  in  A_WIDTH  new PC; bits [1:0] forced to 0
- `mem_en`  out  1  ROM read enable
- `mem_addr`  out  A_WIDTH  ROM byte address (= PC)
- `mem_dout`  in  D_WIDTH  ROM data, valid the cycle after `mem_en`
- `out_valid`  out  1  buffer head valid
- `out_ready`  in  1  decode accepts head
- `out_instr`  out  D_WIDTH  head instruction
- `out_pc`  out  A_WIDTH  head PC
- `busy`  out  1  state != IDLE or buffer non-empty or read in flight

## Operation
- States: IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: `mem_en`=0. `start`=1 -> RUN. `redirect_valid` loads PC, stays IDLE.
- RUN: issue when `count + inflight - pop < 2`, `pop = out_valid & out_ready`. Issue: `mem_en`=1, `mem_addr`=PC, PC += 4 (wraps mod 2^A_WIDTH), `inflight`<=1, `inflight_pc`<=PC. `stop`=1 -> DRAIN; no issue in that cycle.
- DRAIN: no issue; in-flight word still captured; buffer keeps presenting. -> IDLE when `count`=0, `inflight`=0, no capture pending.
- Capture: cycle after an issue, `{mem_dout, inflight_pc}` is written to buffer tail unless squashed.
- Buffer: 2-entry FIFO, push and pop same cycle allowed; never overflows by construction of issue rule.
- Redirect (any state): buffer cleared, `out_valid`<=0, in-flight word squashed (dropped next cycle), PC<=`{redirect_pc[A_WIDTH-1:2],2'b00}`, no issue that cycle. State unchanged except DRAIN with redirect -> IDLE.
- Priority: `rst` > `redirect_valid` > `stop` > `start`. Redirect in same cycle as pop: pop is consumed by decode, then flush.
- `rst` mid-operation: all state cleared in one edge; in-flight data discarded.

## Timing
- Reset values: `mem_en`=0, `mem_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `busy`=0, `count`=0, `inflight`=0.
- `mem_en`, `mem_addr` combinational from state/PC/count/pop; all other outputs registered.
- `start` at cycle N -> first `mem_en` at N+1 -> `out_valid`=1 at N+3.
- Redirect at cycle N -> first issue at N+1 from new PC -> `out_valid` at N+3.
- Steady state with `out_ready`=1: one issue and one output per cycle.
- `out_ready`=0 stall: at most 2 words buffered, issue stops; resumes the cycle `pop`=1.
- `out_instr`/`out_pc` held stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `ISU_FETCH_PERF_EN` defined: adds outputs `perf_fetch_cnt` (32) counting accepted outputs (`pop`) and `perf_stall_cnt` (32) counting cycles with `out_valid`=1, `out_ready`=0; both reset to 0, wrap on overflow, unaffected by redirect.
- Not defined: ports and counters absent; functional behaviour identical.

## Test plan
- Reset, RESET_PC=0, `start` at cycle 1, `out_ready`=1 -> `out_valid` at cycle 4 with `out_pc`=0x0, then 0x4, 0x8, 0xC on consecutive cycles, `out_instr` = ROM words 0..3.
- Steady stream, `out_ready`=0 for 5 cycles -> exactly 2 words buffered, `mem_en`=0 during hold, `out_pc` stable; release -> no word lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x43 while a read is in flight -> squashed word never appears; next outputs `out_pc`=0x40, 0x44.
- `stop` in RUN with 1 buffered + 1 in flight, `out_ready`=1 -> both delivered, then IDLE, `busy`=0, `mem_en` stays 0.
- `rst` asserted mid-stream with `out_valid`=1 -> next cycle all outputs at reset values; `start` refetches from RESET_PC.
- With `ISU_FETCH_PERF_EN`: 10 accepted words and 3 stall cycles -> `perf_fetch_cnt`=10, `perf_stall_cnt`=3.
